// File: rtl/ctrl_word_sequencer.sv
// rtl/ctrl_word_sequencer.sv - program-memory microsequencer feeding an external opcode decoder
// Optional feature macro: CTRL_SEQ_PARITY_EN adds ctl_par = ^ctl_word, registered with ctl_word.
module ctrl_word_sequencer #(
    parameter int DEPTH = 16,
    parameter int OPW   = 7,
    parameter int CTW   = 26,
    parameter int CNTW  = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [OPW+CNTW-1:0] prog_data,
    input  logic                start,
    input  logic [AW:0]         len,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [OPW-1:0]      op_out,
    input  logic [CTW-1:0]      dec_in,
    output logic                ctl_valid,
    input  logic                ctl_ready,
`ifdef CTRL_SEQ_PARITY_EN
    output logic                ctl_par,
`endif
    output logic [CTW-1:0]      ctl_word
);
    localparam int RW = AW + 1;
    localparam int EW = OPW + CNTW;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   pc_q, pc_d;
    logic [CNTW-1:0] rcnt_q, rcnt_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic            ctl_valid_q, ctl_valid_d;
    logic [CTW-1:0]  ctl_word_q, ctl_word_d;
    logic            mem_wr;
    logic            fire;
    logic [OPW-1:0]  cur_op;
    logic [CNTW-1:0] nxt_rpt;
    logic [CNTW-1:0] first_rpt;

    assign mem_wr  = prog_we && (state_q == S_IDLE);
    assign cur_op  = mem_q[pc_q][OPW-1:0];
    assign nxt_rpt = mem_q[pc_q + AW'(1)][EW-1:OPW];
    // Entry 0 is forwarded from a same-cycle write so start+prog_we runs the new contents.
    assign first_rpt = (mem_wr && (prog_addr == '0)) ? prog_data[EW-1:OPW] : mem_q[0][EW-1:OPW];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rcnt_d      = rcnt_q;
        rem_d       = rem_q;
        ctl_valid_d = ctl_valid_q;
        ctl_word_d  = ctl_word_q;
        fire        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    rem_d   = len;
                    rcnt_d  = first_rpt;
                    // An empty run still passes through DRAIN so busy spans two cycles.
                    state_d = (len != '0) ? S_ISSUE : S_DRAIN;
                end
            end
            S_ISSUE: begin
                fire = !ctl_valid_q || ctl_ready;
                if (fire) begin
                    ctl_word_d  = dec_in;
                    ctl_valid_d = 1'b1;
                    if (rcnt_q != '0) begin
                        rcnt_d = rcnt_q - CNTW'(1);
                    end else if (rem_q == RW'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        pc_d   = pc_q + AW'(1);
                        rcnt_d = nxt_rpt;
                        rem_d  = rem_q - RW'(1);
                    end
                end
            end
            S_DRAIN: begin
                ctl_valid_d = ctl_valid_q && !ctl_ready;
                if (!ctl_valid_q || ctl_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            ctl_valid_d = 1'b0;
        end
    end

`ifdef CTRL_SEQ_PARITY_EN
    logic ctl_par_q;
    assign ctl_par = ctl_par_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            rcnt_q      <= '0;
            rem_q       <= '0;
            ctl_valid_q <= 1'b0;
            ctl_word_q  <= '0;
`ifdef CTRL_SEQ_PARITY_EN
            ctl_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rcnt_q      <= rcnt_d;
            rem_q       <= rem_d;
            ctl_valid_q <= ctl_valid_d;
            ctl_word_q  <= ctl_word_d;
`ifdef CTRL_SEQ_PARITY_EN
            ctl_par_q   <= ^ctl_word_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign op_out    = (state_q == S_ISSUE) ? cur_op : '0;
    assign ctl_valid = ctl_valid_q;
    assign ctl_word  = ctl_word_q;

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// tb/tb_ctrl_word_sequencer.sv - randomized bench for ctrl_word_sequencer against a queue-based run model
module tb_ctrl_word_sequencer;
    localparam int BUDGET = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [10:0] prog_data = '0;
    logic        start = 1'b0;
    logic [4:0]  len = '0;
    logic        abort = 1'b0;
    logic        busy, done, ctl_valid;
    logic        ctl_ready = 1'b1;
    logic [6:0]  op_out;
    logic [25:0] dec_in, ctl_word;
`ifdef CTRL_SEQ_PARITY_EN
    logic        ctl_par;
`endif

    int          n_vec = 0;
    int          n_fail = 0;
    int          cur_k = 0;
    int          xfer_cnt = 0;
    int          last_xfer_k = -1;
    logic [10:0] mdl_mem [16];
    logic [25:0] exp_q [$];
    bit          hold_pending = 0;
    logic [25:0] held_w = '0;

    always #5 clk = ~clk;

    function automatic logic [25:0] dec_f(input logic [6:0] op);
        return {op, ~op, op ^ 7'h55, op[4:0]};
    endfunction

    assign dec_in = dec_f(op_out);

    ctrl_word_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .len(len), .abort(abort), .busy(busy), .done(done), .op_out(op_out),
        .dec_in(dec_in), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
`ifdef CTRL_SEQ_PARITY_EN
        .ctl_par(ctl_par),
`endif
        .ctl_word(ctl_word)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur_k);
        end
    endtask

    // Every transfer must deliver the next word of the model's expected stream.
    always @(negedge clk) begin
        logic [25:0] e;
        if (!rst) begin
            if (ctl_valid && ctl_ready) begin
                xfer_cnt++;
                last_xfer_k = cur_k;
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_word", 32'(ctl_word), 32'(e));
`ifdef CTRL_SEQ_PARITY_EN
                    chk("xfer_par", 32'(ctl_par), 32'(^e));
`endif
                end
            end
            if (hold_pending) begin
                chk("stall_hold_valid", 32'(ctl_valid), 1);
                chk("stall_hold_word", 32'(ctl_word), 32'(held_w));
            end
            hold_pending = ctl_valid && !ctl_ready && !abort;
            held_w = ctl_word;
            if (!busy || done) chk("op_out_zero", 32'(op_out), 0);
            if (!busy) chk("valid_idle", 32'(ctl_valid), 0);
        end else begin
            hold_pending = 0;
        end
    end

    task automatic prog_w(input int a, input logic [10:0] d);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic build_exp(input int len_v, output int w);
        logic [10:0] ent;
        w = 0;
        exp_q.delete();
        for (int e = 0; e < len_v; e++) begin
            ent = mdl_mem[e % 16];
            for (int r = 0; r <= int'(ent[10:7]); r++) begin
                exp_q.push_back(dec_f(ent[6:0]));
                w++;
            end
        end
    endtask

    // rmode: 0 ready always, 1 ready low for cycles 2..6, 2 random ready plus spurious start/prog_we while busy.
    task automatic run_seq(input int len_v, input int rmode, input int abort_at, input int we_at,
                           input int sw_addr, input logic [10:0] sw_data, input int probe_k,
                           output int nxfer, output int first_v, output int done_cyc,
                           output int busy_cyc, output int done_n, output int end_k,
                           output logic [25:0] probe_word, output logic [6:0] probe_op,
                           output bit aborted);
        int w, k, x0, abort_k;
        bit can_inj, b, d;
        first_v = -1; done_cyc = -1; busy_cyc = 0; done_n = 0; aborted = 0; abort_k = -1;
        probe_word = '0; probe_op = '0;
        @(posedge clk); #1;
        if (sw_addr >= 0) begin
            prog_we = 1'b1; prog_addr = 4'(sw_addr); prog_data = sw_data;
            mdl_mem[sw_addr] = sw_data;
        end
        build_exp(len_v, w);
        x0 = xfer_cnt;
        cur_k = 0;
        start = 1'b1;
        len = 5'(len_v);
        @(negedge clk);
        chk("idle_before_start", 32'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0; prog_we = 1'b0;
        k = 1;
        can_inj = 1;
        while (1) begin
            cur_k = k;
            if (rmode == 0) ctl_ready = 1'b1;
            else if (rmode == 1) ctl_ready = !(k >= 2 && k <= 6);
            else ctl_ready = ($urandom_range(0, 3) != 0);
            abort = can_inj && (k == abort_at);
            if (can_inj && k == we_at) begin
                prog_we = 1'b1; prog_addr = 4'd1; prog_data = {4'd0, 7'h11};
            end
            if (rmode == 2 && can_inj) begin
                start = ($urandom_range(0, 9) == 0);
                len = 5'($urandom_range(0, 16));
                if ($urandom_range(0, 7) == 0) begin
                    prog_we = 1'b1; prog_addr = 4'($urandom); prog_data = 11'($urandom);
                end
            end
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin done_n++; done_cyc = k; end
            if (ctl_valid && first_v < 0) first_v = k;
            if (k == probe_k) begin probe_word = ctl_word; probe_op = op_out; end
            if (abort && !done) begin aborted = 1; abort_k = k; end
            b = busy; d = done;
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0; prog_we = 1'b0;
            if (!b) break;
            can_inj = b && !d && !aborted;
            k++;
            if (k > BUDGET) begin
                chk("run_timeout", k, BUDGET);
                break;
            end
        end
        end_k = k;
        nxfer = xfer_cnt - x0;
        if (aborted) begin
            chk("abort_no_done", done_n, 0);
            chk("abort_idle_next", end_k, abort_k + 1);
            exp_q.delete();
        end else begin
            chk("run_done_once", done_n, 1);
            chk("run_all_words", nxfer, w);
            chk("run_queue_empty", exp_q.size(), 0);
            chk("busy_span", busy_cyc, done_cyc);
            chk("idle_after_done", end_k, done_cyc + 1);
            if (w > 0) chk("done_after_last_xfer", done_cyc, last_xfer_k + 1);
            else chk("empty_run_no_valid", first_v, -1);
            if (rmode == 0) chk("full_rate", done_cyc, w + 2);
        end
    endtask

    initial begin
        int nx, fv, dc, bc, dn, ek, lv, ab_at, w;
        logic [25:0] pw;
        logic [6:0] po;
        bit ab;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_op_out", 32'(op_out), 0);
        chk("rst_valid", 32'(ctl_valid), 0);
        chk("rst_word", 32'(ctl_word), 0);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) prog_w(a, 11'($urandom));
        prog_w(0, {4'd0, 7'h05});
        prog_w(1, {4'd2, 7'h3A});

        run_seq(2, 0, -1, -1, -1, '0, -1, nx, fv, dc, bc, dn, ek, pw, po, ab);
        chk("basic_words", nx, 4);
        chk("basic_first_valid", fv, 2);
        chk("basic_done_cycle", dc, 6);
        chk("basic_busy_cycles", bc, 6);

        run_seq(2, 1, -1, -1, -1, '0, 6, nx, fv, dc, bc, dn, ek, pw, po, ab);
        chk("stall_frozen_word", 32'(pw), 32'(dec_f(7'h05)));
        chk("stall_op_hold", 32'(po), 32'h3A);
        chk("stall_words", nx, 4);
        chk("stall_done_cycle", dc, 11);

        run_seq(0, 0, -1, -1, -1, '0, -1, nx, fv, dc, bc, dn, ek, pw, po, ab);
        chk("len0_busy", bc, 2);
        chk("len0_done", dn, 1);

        run_seq(2, 0, 3, -1, -1, '0, -1, nx, fv, dc, bc, dn, ek, pw, po, ab);
        chk("abort_idle_at_4", ek, 4);
        chk("abort_flag", 32'(ab), 1);
        chk("abort_words", nx, 2);
        run_seq(2, 0, -1, -1, -1, '0, -1, nx, fv, dc, bc, dn, ek, pw, po, ab);
        chk("replay_words", nx, 4);

        run_seq(2, 0, -1, 2, -1, '0, -1, nx, fv, dc, bc, dn, ek, pw, po, ab);
        chk("busy_write_run", nx, 4);
        run_seq(2, 0, -1, -1, -1, '0, -1, nx, fv, dc, bc, dn, ek, pw, po, ab);
        chk("busy_write_dropped", nx, 4);

        run_seq(2, 0, -1, -1, 0, {4'd1, 7'h22}, -1, nx, fv, dc, bc, dn, ek, pw, po, ab);
        chk("start_with_write", nx, 5);

        for (int it = 0; it < 14; it++) begin
            repeat ($urandom_range(1, 4)) prog_w($urandom_range(0, 15), 11'($urandom));
            lv = (it == 0) ? 16 : $urandom_range(0, 16);
            ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
            run_seq(lv, (it == 1) ? 0 : 2, ab_at, -1, -1, '0, -1, nx, fv, dc, bc, dn, ek, pw, po, ab);
        end

        @(posedge clk); #1;
        build_exp(2, w);
        ctl_ready = 1'b1; start = 1'b1; len = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_done", 32'(done), 0);
        chk("async_rst_op_out", 32'(op_out), 0);
        chk("async_rst_valid", 32'(ctl_valid), 0);
        chk("async_rst_word", 32'(ctl_word), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 0);
            chk("post_rst_idle", 32'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
